// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu command driver and its command FIFO.
//   ALU_WIDTH / ALU_OPW : default operand and opcode widths of the alu
//   FLAG_*              : bit positions inside the packed {S,P,C,Z} flag word
//   state_t             : driver FSM states
//   pack_flags()        : builds the packed flag word from the four alu flags
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int ALU_OPW   = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_P = 2;
    localparam int FLAG_S = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] pack_flags(
        input logic i_s,
        input logic i_p,
        input logic i_c,
        input logic i_z
    );
        logic [3:0] v_f;
        v_f         = 4'b0000;
        v_f[FLAG_S] = i_s;
        v_f[FLAG_P] = i_p;
        v_f[FLAG_C] = i_c;
        v_f[FLAG_Z] = i_z;
        return v_f;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO holding queued alu commands. Head entry is visible on
// o_data whenever the FIFO is non-empty (show-ahead read).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (empties the FIFO)
//   i_push   in   write i_data (ignored when full)
//   i_data   in   DW-bit entry to write
//   i_pop    in   drop the head entry (ignored when empty)
//   o_data   out  head entry
//   o_full   out  no free entry
//   o_empty  out  no valid entry
//
// Pointers carry one extra wrap bit: equal index with differing wrap bit is
// full, fully equal pointers are empty.
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_same_idx;

    assign w_same_idx = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty    = w_same_idx && (r_wr_ptr[AW] == r_rd_ptr[AW]);
    assign o_full     = w_same_idx && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop  && !o_empty;

    assign o_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
// Sequential initiator for the 8-bit combinational alu. Commands arrive on a
// valid/ready stream, are queued in alu_cmd_fifo, driven one at a time into
// the alu from registers, and the captured result/flags are returned on a
// valid/ready response stream in strict command order.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b      opcode and operands
//   alu_a, alu_b, alu_d       registered drive into alu A/B/D
//   alu_out, alu_z/c/p/s      alu result and flags
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_flags, rsp_op  captured result, {S,P,C,Z}, source opcode
//   err                       sticky zero-flag consistency error
//
// Build option: define ALU_CMD_DRIVER_CHECK_EN to enable the zero-flag
// consistency check; otherwise err is constant 0.
//
// FSM:
//   state | meaning
//   IDLE  | nothing in flight, waiting for a queued command
//   EXEC  | command on alu inputs, alu settling this cycle
//   RESP  | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_d,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_p,
    input  logic             alu_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [OPW-1:0]   rsp_op,
    output logic             err
);

    localparam int FW = OPW + 2 * WIDTH;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [FW-1:0]    w_fifo_wdata;
    logic [FW-1:0]    w_fifo_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_rsp_done;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_d;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [3:0]       r_rsp_flags;
    logic [OPW-1:0]   r_rsp_op;

    // No bypass: a full FIFO refuses a push even if a pop happens this cycle.
    assign cmd_ready    = !w_full;
    assign w_push       = cmd_valid && !w_full;
    assign w_fifo_wdata = {cmd_op, cmd_a, cmd_b};

    alu_cmd_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = w_empty ? IDLE : EXEC;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop = !w_empty;
            end
            EXEC: begin
                w_capture = 1'b1;
            end
            RESP: begin
                // Chaining the next pop on the accepting cycle keeps the
                // steady-state rate at one response every two cycles.
                w_rsp_done = rsp_ready;
                w_pop      = rsp_ready && !w_empty;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: alu drive registers and response capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_d     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_op    <= '0;
        end else begin
            // alu inputs keep the last command between operations.
            if (w_pop) begin
                {r_alu_d, r_alu_a, r_alu_b} <= w_fifo_rdata;
            end
            if (w_capture) begin
                r_rsp_data  <= alu_out;
                r_rsp_flags <= pack_flags(alu_s, alu_p, alu_c, alu_z);
                r_rsp_op    <= r_alu_d;
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_d     = r_alu_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_op    = r_rsp_op;

`ifdef ALU_CMD_DRIVER_CHECK_EN
    logic r_err;

    // Zero flag must agree with the result it describes; latch any miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_capture && (alu_z != (alu_out == '0))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_d;
    logic [7:0] alu_out;
    logic       alu_z;
    logic       alu_c;
    logic       alu_p;
    logic       alu_s;
    logic       w_z_raw;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic [3:0] rsp_op;
    logic       err;
    logic       force_z0 = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_push = 0;
    int n_rsp = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] data;
        logic [3:0] flags;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(8), .OPW(4), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_d     (alu_d),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_p     (alu_p),
        .alu_s     (alu_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_op    (rsp_op),
        .err       (err)
    );

    // Golden alu: returns {S,P,C,Z,out}. Also drives the alu stub below.
    function automatic logic [11:0] alu_model(input logic [3:0] op,
                                               input logic [7:0] a,
                                               input logic [7:0] b);
        logic [8:0] t;
        case (op)
            4'd0:    t = {1'b0, a} + {1'b0, b};
            4'd1:    t = {1'b0, a} - {1'b0, b};
            4'd2:    t = {1'b0, a & b};
            4'd3:    t = {1'b0, a | b};
            4'd4:    t = {1'b0, a ^ b};
            4'd5:    t = {1'b0, ~a};
            4'd6:    t = {a, 1'b0};
            4'd7:    t = {a[0], 1'b0, a[7:1]};
            4'd8:    t = {1'b0, a} + 9'd1;
            4'd9:    t = {1'b0, a} - 9'd1;
            4'd10:   t = {1'b0, a};
            4'd11:   t = {1'b0, b};
            4'd12:   t = {1'b0, ~(a & b)};
            4'd13:   t = {1'b0, ~(a | b)};
            4'd14:   t = {1'b0, ~(a ^ b)};
            default: t = {1'b0, b} - {1'b0, a};
        endcase
        return {t[7], ~^t[7:0], t[8], (t[7:0] == 8'h00), t[7:0]};
    endfunction

    assign {alu_s, alu_p, alu_c, w_z_raw, alu_out} = alu_model(alu_d, alu_a, alu_b);
    assign alu_z = force_z0 ? 1'b0 : w_z_raw;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge.
    logic       r_hold = 1'b0;
    logic [7:0] h_data;
    logic [3:0] h_flags;
    logic [3:0] h_op;

    always @(negedge clk) begin
        logic [11:0] m;
        exp_t        e;
        if (rst) begin
            sb.delete();
            r_hold = 1'b0;
        end else begin
            if (r_hold) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_data",  32'(rsp_data),  32'(h_data));
                check("hold_flags", 32'(rsp_flags), 32'(h_flags));
                check("hold_op",    32'(rsp_op),    32'(h_op));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_op",    32'(rsp_op),    32'(e.op));
                    check("rsp_data",  32'(rsp_data),  32'(e.data));
                    check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                end
                n_rsp++;
            end
            if (cmd_valid && cmd_ready) begin
                m = alu_model(cmd_op, cmd_a, cmd_b);
                e.op    = cmd_op;
                e.data  = m[7:0];
                e.flags = {m[11:9], force_z0 ? 1'b0 : m[8]};
                sb.push_back(e);
                n_push++;
            end
            r_hold  = rsp_valid && !rsp_ready;
            h_data  = rsp_data;
            h_flags = rsp_flags;
            h_op    = rsp_op;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    // Holds cmd_valid until accepted; leaves cmd_valid high for back-to-back use.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int stalls);
        logic acc;
        int   budget;
        stalls    = 0;
        budget    = 300;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            if (!acc) stalls++;
            budget--;
        end while (!acc && budget > 0);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 2000;
        while ((sb.size() != 0 || rsp_valid) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_timeout", 32'(budget > 0), 32'd1);
    endtask

    task automatic wait_rsp_valid();
        int budget;
        budget = 100;
        @(negedge clk);
        while (!rsp_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        logic [11:0] g;
        int          st;
        int          total_st;
        int          base;
        int          acc_cnt;
        int          idx;
        logic [7:0]  s_data;
        logic [3:0]  s_flags;
        logic [3:0]  s_op;
        logic        done;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;

        // 1: reset state
        do_reset(2);
        @(negedge clk);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_b",     32'(alu_b),     32'd0);
        check("rst_alu_d",     32'(alu_d),     32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst_rsp_op",    32'(rsp_op),    32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // 2: single command latency
        tick();
        g         = alu_model(4'd0, 8'hFA, 8'h63);
        cmd_op    = 4'd0;
        cmd_a     = 8'hFA;
        cmd_b     = 8'h63;
        cmd_valid = 1'b1;
        tick();
        idle();
        @(negedge clk);
        check("lat_n0_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_n1_valid", 32'(rsp_valid), 32'd0);
        check("lat_n1_alu_a", 32'(alu_a), 32'hFA);
        check("lat_n1_alu_b", 32'(alu_b), 32'h63);
        check("lat_n1_alu_d", 32'(alu_d), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(rsp_valid), 32'd1);
        check("single_op",    32'(rsp_op),    32'd0);
        check("single_data",  32'(rsp_data),  32'(g[7:0]));
        check("single_flags", 32'(rsp_flags), 32'(g[11:8]));
        wait_drain();
        repeat (3) tick();
        check("alu_a_kept", 32'(alu_a), 32'hFA);
        check("alu_b_kept", 32'(alu_b), 32'h63);

        // 3: all opcodes back-to-back
        base     = n_rsp;
        total_st = 0;
        for (int op = 0; op < 16; op++) begin
            send(4'(op), 8'hFA, 8'h63, st);
            total_st += st;
        end
        idle();
        wait_drain();
        check("b2b_count", 32'(n_rsp - base), 32'd16);
        check("b2b_backpressure", 32'(total_st > 0), 32'd1);

        // 4: fill with rsp_ready low, hold, then drain
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        idx       = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'(idx);
            cmd_a     = 8'(8'h30 + idx);
            cmd_b     = 8'(8'hC5 - 3 * idx);
            @(negedge clk);
            if (cmd_ready) begin
                acc_cnt++;
                idx++;
            end
            tick();
        end
        idle();
        @(negedge clk);
        check("fill_accepted",  32'(acc_cnt),   32'(DEPTH + 1));
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_rsp_valid", 32'(rsp_valid), 32'd1);
        s_data  = rsp_data;
        s_flags = rsp_flags;
        s_op    = rsp_op;
        repeat (20) @(negedge clk);
        check("stall_data",  32'(rsp_data),  32'(s_data));
        check("stall_flags", 32'(rsp_flags), 32'(s_flags));
        check("stall_op",    32'(rsp_op),    32'(s_op));
        tick();
        base      = n_rsp;
        rsp_ready = 1'b1;
        wait_drain();
        check("fill_drain_count", 32'(n_rsp - base), 32'(DEPTH + 1));

        // 5: zero result sets Z; forced inconsistent Z sets err
        rsp_ready = 1'b0;
        send(4'd0, 8'h00, 8'h00, st);
        idle();
        wait_rsp_valid();
        check("zero_flag_z", 32'(rsp_flags[FLAG_Z]), 32'd1);
        check("zero_data",   32'(rsp_data),          32'd0);
        tick();
        rsp_ready = 1'b1;
        wait_drain();
        check("err_clean", 32'(err), 32'd0);
        force_z0 = 1'b1;
        send(4'd0, 8'h00, 8'h00, st);
        idle();
        wait_drain();
        force_z0 = 1'b0;
`ifdef ALU_CMD_DRIVER_CHECK_EN
        check("err_set", 32'(err), 32'd1);
        send(4'd2, 8'h0F, 8'hF3, st);
        idle();
        wait_drain();
        check("err_sticky", 32'(err), 32'd1);
`else
        check("err_tied0", 32'(err), 32'd0);
`endif
        do_reset(1);
        @(negedge clk);
        check("err_after_rst", 32'(err), 32'd0);

        // 1b: reset in RESP discards in-flight and queued commands
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(4'(i + 3), 8'(8'h11 * (i + 1)), 8'h5A, st);
        end
        idle();
        wait_rsp_valid();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        base = n_rsp;
        repeat (12) tick();
        check("rst_mid_no_rsp", 32'(n_rsp - base), 32'd0);
        check("rst_mid_valid_late", 32'(rsp_valid), 32'd0);

        // 6: random traffic with random rsp_ready
        base = n_rsp;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), st);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        tick();
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();
        check("rand_count", 32'(n_rsp - base), 32'd200);
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
